// File: rtl/lsu_pkg.sv
// Shared LSU types: access sizes, data-memory FSM states and the
// size/alignment helpers used by both the store and load paths.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        DM_CLEAR,
        DM_READY
    } dmem_state_e;

    function automatic logic size_legal(size_e size, logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return addr_lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(size_e size, logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-aligned store data copied onto every lane it could target.
    function automatic logic [31:0] lane_replicate(size_e size, logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// LSU <-> data-memory bus: store request, load request, stall and the
// registered load response / fault / busy returned by the memory.
interface lsu_dmem_if;
    logic        stall;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [1:0]  wr_size;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [1:0]  rd_size;
    logic        rd_zero_ext;
    logic [31:0] rd_data;
    logic        misalign_fault;
    logic        busy;

    modport master (
        output stall, wr_addr, wr_data, wr_en, wr_size,
        output rd_addr, rd_en, rd_size, rd_zero_ext,
        input  rd_data, misalign_fault, busy
    );

    modport slave (
        input  stall, wr_addr, wr_data, wr_en, wr_size,
        input  rd_addr, rd_en, rd_size, rd_zero_ext,
        output rd_data, misalign_fault, busy
    );
endinterface

// File: rtl/lsu_dmem_align.sv
// Load alignment: picks the addressed lane(s) out of a raw word, shifts them
// to bit 0 and sign- or zero-extends byte/half results.
module lsu_dmem_align
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        zero_ext,
    output logic [31:0] data
);
    logic [31:0] shifted;

    always_comb begin
        shifted = raw >> {addr_lo, 3'b000};
        data    = '0;
        case (size)
            SZ_BYTE: data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
            SZ_WORD: data = raw;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/lsu_dmem.sv
// Data-memory responder: byte-lane array with 0-cycle store commit, 1-cycle
// aligned load response, write-first bypass and post-reset zero fill.
//   state    | meaning
//   DM_CLEAR | zeroing word[clr_cnt] each cycle, busy=1, requests ignored
//   DM_READY | servicing loads and stores
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input logic       clk,
    input logic       rst,
    lsu_dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e     state, state_nxt;
    logic [AW-1:0]   clr_cnt;
    logic            busy, clr_we, clr_last;
    logic [3:0][7:0] mem [DEPTH_WORDS];

    size_e           wr_size, rd_size;
    logic [AW-1:0]   wr_idx, rd_idx;
    logic            wr_ok, wr_bad, rd_ok, rd_bad;
    logic [3:0]      wr_be;
    logic [31:0]     wr_rep, rd_raw, rd_aligned;
    logic [31:0]     rd_q;
    logic            fault_q;
    logic            unused_addr_hi;

    assign clr_last = clr_cnt == AW'(DEPTH_WORDS - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR_ON_RST ? DM_CLEAR : DM_READY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            DM_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_last) state_nxt = DM_READY;
            end
            DM_READY: state_nxt = DM_READY;
            default:  state_nxt = DM_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         clr_cnt <= '0;
        else if (clr_we) clr_cnt <= clr_cnt + AW'(1);
    end

    assign wr_size = size_e'(bus.wr_size);
    assign rd_size = size_e'(bus.rd_size);
    assign wr_idx  = bus.wr_addr[AW+1:2];
    assign rd_idx  = bus.rd_addr[AW+1:2];
    assign wr_ok   = !busy && bus.wr_en &&  size_legal(wr_size, bus.wr_addr[1:0]);
    assign wr_bad  = !busy && bus.wr_en && !size_legal(wr_size, bus.wr_addr[1:0]);
    assign rd_ok   = !busy && bus.rd_en &&  size_legal(rd_size, bus.rd_addr[1:0]);
    assign rd_bad  = !busy && bus.rd_en && !size_legal(rd_size, bus.rd_addr[1:0]);
    assign wr_be   = wr_ok ? byte_en(wr_size, bus.wr_addr[1:0]) : 4'b0000;
    assign wr_rep  = lane_replicate(wr_size, bus.wr_data);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (wr_be[i]) mem[wr_idx][i] <= wr_rep[8*i +: 8];
            end
        end
    end

    // A same-word store in this cycle wins on the lanes it enables.
    always_comb begin
        rd_raw = mem[rd_idx];
        if (wr_idx == rd_idx) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i]) rd_raw[8*i +: 8] = wr_rep[8*i +: 8];
        end
    end

    lsu_dmem_align u_align (
        .raw      (rd_raw),
        .addr_lo  (bus.rd_addr[1:0]),
        .size     (rd_size),
        .zero_ext (bus.rd_zero_ext),
        .data     (rd_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst || busy) begin
            rd_q    <= '0;
            fault_q <= 1'b0;
        end else if (!bus.stall) begin
            rd_q    <= rd_ok ? rd_aligned : '0;
            fault_q <= rd_bad | wr_bad;
        end
    end

    assign bus.rd_data        = rd_q;
    assign bus.misalign_fault = fault_q;
    assign bus.busy           = busy;

    // Upper address bits alias onto the array and are intentionally dropped.
    assign unused_addr_hi = ^{bus.wr_addr[31:AW+2], bus.rd_addr[31:AW+2]};
endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: byte-array reference model, per-cycle compare process,
// directed scenarios with literal pins, then randomized traffic.
module tb_lsu_dmem;
    localparam int DEPTH = 16;
    localparam bit CLR   = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_dmem_if bus_if ();

    lsu_dmem #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RST(CLR)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [7:0]  mmem [DEPTH*4];
    logic [31:0] exp_rd    = '0;
    logic        exp_fault = 1'b0;
    int          busy_left = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mlegal(logic [31:0] a, int sz);
        if (sz == 3) return 1'b0;
        return (a % (1 << sz)) == 0;
    endfunction

    function automatic int mbase(logic [31:0] a);
        return int'((a >> 2) % DEPTH) * 4 + int'(a % 4);
    endfunction

    function automatic logic [31:0] mload(logic [31:0] a, int sz, bit zx);
        int nb;
        int base;
        logic [31:0] v, mask;
        nb   = 1 << sz;
        base = mbase(a);
        v    = '0;
        for (int k = 0; k < nb; k++) v |= 32'(mmem[base + k]) << (8 * k);
        if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            if (!zx && v[8*nb-1]) v |= ~mask;
        end
        return v;
    endfunction

    task automatic mstore(logic [31:0] a, logic [31:0] d, int sz);
        int nb;
        int base;
        nb   = 1 << sz;
        base = mbase(a);
        for (int k = 0; k < nb; k++) mmem[base + k] = 8'(d >> (8 * k));
    endtask

    // Reference model: store applied before the load is looked up (write-first).
    always @(posedge clk) begin
        bit wl, rl;
        wl = mlegal(bus_if.wr_addr, int'(bus_if.wr_size));
        rl = mlegal(bus_if.rd_addr, int'(bus_if.rd_size));
        if (rst) begin
            exp_rd    = '0;
            exp_fault = 1'b0;
            busy_left = CLR ? DEPTH : 0;
            foreach (mmem[i]) mmem[i] = 8'h00;
        end else if (busy_left > 0) begin
            busy_left--;
            exp_rd    = '0;
            exp_fault = 1'b0;
        end else begin
            if (bus_if.wr_en && wl) mstore(bus_if.wr_addr, bus_if.wr_data, int'(bus_if.wr_size));
            if (!bus_if.stall) begin
                exp_fault = (bus_if.wr_en && !wl) || (bus_if.rd_en && !rl);
                exp_rd    = (bus_if.rd_en && rl) ?
                            mload(bus_if.rd_addr, int'(bus_if.rd_size), bus_if.rd_zero_ext) : '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_data", bus_if.rd_data, exp_rd);
            check("fault", {31'b0, bus_if.misalign_fault}, {31'b0, exp_fault});
            check("busy", {31'b0, bus_if.busy}, {31'b0, busy_left > 0});
        end
    end

    task automatic idle();
        bus_if.stall       = 1'b0;
        bus_if.wr_en       = 1'b0;
        bus_if.wr_addr     = '0;
        bus_if.wr_data     = '0;
        bus_if.wr_size     = 2'b00;
        bus_if.rd_en       = 1'b0;
        bus_if.rd_addr     = '0;
        bus_if.rd_size     = 2'b00;
        bus_if.rd_zero_ext = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic put_store(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        bus_if.wr_en = 1'b1; bus_if.wr_addr = a; bus_if.wr_data = d; bus_if.wr_size = sz;
    endtask

    task automatic put_load(logic [31:0] a, logic [1:0] sz, logic zx);
        bus_if.rd_en = 1'b1; bus_if.rd_addr = a; bus_if.rd_size = sz; bus_if.rd_zero_ext = zx;
    endtask

    task automatic lit(string nm, logic [31:0] v, logic f);
        @(negedge clk);
        check(nm, bus_if.rd_data, v);
        check({nm, "_model"}, exp_rd, v);
        check({nm, "_flt"}, {31'b0, bus_if.misalign_fault}, {31'b0, f});
    endtask

    task automatic count_busy(string nm);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.busy) n++;
        end
        check(nm, n, 16);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy("busy_len");

        put_load(32'h3C, 2'b10, 1'b0); step(); lit("lw_3c", 32'h0, 1'b0);

        put_store(32'h8, 32'hDEADBEEF, 2'b10); step();
        put_load(32'h9, 2'b00, 1'b0); step(); lit("lb_9", 32'hFFFFFFBE, 1'b0);
        put_load(32'hA, 2'b01, 1'b1); step(); lit("lhu_a", 32'h0000DEAD, 1'b0);
        put_load(32'h8, 2'b10, 1'b0); step(); lit("lw_8", 32'hDEADBEEF, 1'b0);

        put_store(32'hB, 32'h12, 2'b00); step();
        put_load(32'h8, 2'b10, 1'b0); step(); lit("lw_8_sb", 32'h12ADBEEF, 1'b0);
        put_store(32'h9, 32'h5555, 2'b01); step(); lit("sh_9", 32'h0, 1'b1);
        put_load(32'h8, 2'b10, 1'b0); step(); lit("lw_8_keep", 32'h12ADBEEF, 1'b0);

        put_store(32'h4, 32'h11223344, 2'b10); step();
        put_store(32'h4, 32'hAAAA, 2'b01); put_load(32'h4, 2'b10, 1'b0); step();
        lit("bypass", 32'h1122AAAA, 1'b0);

        put_store(32'h10, 32'hCAFEF00D, 2'b10); step();
        put_load(32'h10, 2'b10, 1'b0); step();
        for (int k = 0; k < 3; k++) begin
            bus_if.stall = 1'b1;
            put_load(32'h8 + 32'(4 * k), 2'b10, 1'b0);
            @(posedge clk); #1;
            lit("stall_hold", 32'hCAFEF00D, 1'b0);
        end
        idle();
        put_load(32'h10, 2'b11, 1'b0); step(); lit("ill_load", 32'h0, 1'b1);

        rst = 1'b1; step(); rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1; step(); rst = 1'b0;
        count_busy("busy_restart");
        put_store(32'h40, 32'h5A5A1234, 2'b10); step();
        put_load(32'h0, 2'b10, 1'b0); step(); lit("alias", 32'h5A5A1234, 1'b0);

        for (int it = 0; it < 800; it++) begin
            bus_if.stall       = ($urandom_range(0, 4) == 0);
            bus_if.wr_en       = $urandom_range(0, 1) == 1;
            bus_if.wr_addr     = 32'($urandom_range(0, 127));
            bus_if.wr_data     = $urandom;
            bus_if.wr_size     = 2'($urandom_range(0, 3));
            bus_if.rd_en       = $urandom_range(0, 4) != 0;
            bus_if.rd_addr     = 32'($urandom_range(0, 127));
            bus_if.rd_size     = 2'($urandom_range(0, 3));
            bus_if.rd_zero_ext = $urandom_range(0, 1) == 1;
            rst                = (it == 400);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
